// File: rtl/fc_layer_engine.sv
// Fully-connected layer engine: y = act(W*x + b) with runtime-loadable weight/bias storage,
// P parallel MAC lanes, optional saturation and ReLU, valid/ready on both sides.
module fc_layer_engine #(
  parameter int N    = 8,
  parameter int M    = 8,
  parameter int T    = 16,
  parameter int P    = 2,
  parameter int RELU = 1,
  parameter int SAT  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic signed [T-1:0]         data_in,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic signed [T-1:0]         data_out,
  input  logic                        cfg_we,
  input  logic                        cfg_sel,
  input  logic [$clog2(M*N)-1:0]      cfg_addr,
  input  logic signed [T-1:0]         cfg_data,
  output logic                        busy
);

  localparam int AW     = 2*T + $clog2(N) + 1;
  localparam int G      = M / P;
  localparam int AW_CFG = $clog2(M*N);
  localparam int RW     = (M > 1) ? $clog2(M) : 1;
  localparam int CW     = $clog2(N);
  localparam int GW     = (G > 1) ? $clog2(G) : 1;
  localparam int KW     = $clog2(N + 2);
  localparam int OW     = $clog2(M + 1);

  if (M % P != 0) begin : g_bad_lanes
    $error("fc_layer_engine: M must be a multiple of P");
  end

  typedef enum logic [1:0] {IDLE, LOAD, MAC, OUT} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         lcnt_q, lcnt_d;
  logic [GW-1:0]         grp_q, grp_d;
  logic [KW-1:0]         kcnt_q, kcnt_d;
  logic [OW-1:0]         ocnt_q, ocnt_d;
  logic                  m_valid_q, m_valid_d;
  logic signed [T-1:0]   dout_q, dout_d;
  logic                  vld_p0_q, vld_p0_d;
  logic                  vld_p1_q, vld_p1_d;

  logic signed [T-1:0]   w_mem [M*N];
  logic signed [T-1:0]   b_mem [M];
  logic signed [T-1:0]   x_mem [N];
  logic signed [T-1:0]   y_mem [M];

  logic signed [T-1:0]   w_p0_q [P];
  logic signed [T-1:0]   w_p0_d [P];
  logic signed [T-1:0]   x_p0_q, x_p0_d;
  logic signed [2*T-1:0] prod_p1_q [P];
  logic signed [2*T-1:0] prod_p1_d [P];
  logic signed [AW-1:0]  acc_p2_q [P];
  logic signed [AW-1:0]  acc_p2_d [P];
  logic signed [AW-1:0]  sum_c [P];
  logic signed [T-1:0]   y_new [P];
  logic [RW-1:0]         y_idx [P];
  logic [CW-1:0]         rd_col;

  logic                  s_fire, x_we, y_we, cfg_w_en, cfg_b_en;
  logic [CW-1:0]         x_idx;

  function automatic logic signed [T-1:0] sat_fn(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] hi;
    logic signed [AW-1:0] lo;
    hi = {{(AW-T+1){1'b0}}, {(T-1){1'b1}}};
    lo = {{(AW-T+1){1'b1}}, {(T-1){1'b0}}};
    if (SAT == 0)    return v[T-1:0];
    else if (v > hi) return hi[T-1:0];
    else if (v < lo) return lo[T-1:0];
    else             return v[T-1:0];
  endfunction

  function automatic logic signed [T-1:0] relu_fn(input logic signed [T-1:0] v);
    if (RELU != 0 && v[T-1]) return '0;
    return v;
  endfunction

  assign s_ready  = ((state_q == IDLE) || (state_q == LOAD)) && !reset;
  assign busy     = (state_q != IDLE);
  assign m_valid  = m_valid_q;
  assign data_out = dout_q;
  assign s_fire   = s_valid && s_ready;
  assign cfg_w_en = cfg_we && (state_q == IDLE) && !cfg_sel;
  assign cfg_b_en = cfg_we && (state_q == IDLE) && cfg_sel;

  always_comb begin
    state_d   = state_q;
    lcnt_d    = lcnt_q;
    grp_d     = grp_q;
    kcnt_d    = kcnt_q;
    ocnt_d    = ocnt_q;
    m_valid_d = m_valid_q;
    dout_d    = dout_q;
    x_we      = 1'b0;
    x_idx     = lcnt_q;
    y_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_fire) begin
          x_we    = 1'b1;
          x_idx   = '0;
          lcnt_d  = CW'(1);
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (s_fire) begin
          x_we = 1'b1;
          if (lcnt_q == CW'(N-1)) begin
            state_d = MAC;
            lcnt_d  = '0;
            grp_d   = '0;
            kcnt_d  = '0;
          end else begin
            lcnt_d = lcnt_q + CW'(1);
          end
        end
      end
      MAC: begin
        // Group slot: read, N multiplies, then accumulate/writeback on the last cycle
        if (kcnt_q == KW'(N+1)) begin
          y_we   = !reset;
          kcnt_d = '0;
          if (grp_q == GW'(G-1)) begin
            state_d = OUT;
            grp_d   = '0;
            ocnt_d  = '0;
          end else begin
            grp_d = grp_q + GW'(1);
          end
        end else begin
          kcnt_d = kcnt_q + KW'(1);
        end
      end
      OUT: begin
        // Output register refills whenever it is empty or being drained
        if (!m_valid_q || m_ready) begin
          if (ocnt_q == OW'(M)) begin
            m_valid_d = 1'b0;
            ocnt_d    = '0;
            state_d   = IDLE;
          end else begin
            m_valid_d = 1'b1;
            dout_d    = y_mem[RW'(ocnt_q)];
            ocnt_d    = ocnt_q + OW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_col   = (kcnt_q < KW'(N)) ? CW'(kcnt_q) : '0;
    vld_p0_d = (state_q == MAC) && (kcnt_q < KW'(N));
    vld_p1_d = vld_p0_q;
    x_p0_d   = x_mem[rd_col];
    for (int p = 0; p < P; p++) begin
      int row;
      row          = int'(grp_q) * P + p;
      y_idx[p]     = RW'(row);
      w_p0_d[p]    = w_mem[AW_CFG'(row * N + int'(rd_col))];
      prod_p1_d[p] = (2*T)'(w_p0_q[p]) * (2*T)'(x_p0_q);
      sum_c[p]     = acc_p2_q[p] + $signed({{(AW-2*T){prod_p1_q[p][2*T-1]}}, prod_p1_q[p]});
      if (kcnt_q == '0)
        acc_p2_d[p] = $signed({{(AW-T){b_mem[y_idx[p]][T-1]}}, b_mem[y_idx[p]]});
      else if (vld_p1_q)
        acc_p2_d[p] = sum_c[p];
      else
        acc_p2_d[p] = acc_p2_q[p];
      y_new[p]     = relu_fn(sat_fn(sum_c[p]));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lcnt_q    <= '0;
      grp_q     <= '0;
      kcnt_q    <= '0;
      ocnt_q    <= '0;
      m_valid_q <= 1'b0;
      dout_q    <= '0;
      vld_p0_q  <= 1'b0;
      vld_p1_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lcnt_q    <= lcnt_d;
      grp_q     <= grp_d;
      kcnt_q    <= kcnt_d;
      ocnt_q    <= ocnt_d;
      m_valid_q <= m_valid_d;
      dout_q    <= dout_d;
      vld_p0_q  <= vld_p0_d;
      vld_p1_q  <= vld_p1_d;
    end
  end

  // p0: operand read, p1: registered product, p2: accumulator; storage is never reset
  always_ff @(posedge clk) begin
    w_p0_q    <= w_p0_d;
    x_p0_q    <= x_p0_d;
    prod_p1_q <= prod_p1_d;
    acc_p2_q  <= acc_p2_d;
    if (cfg_w_en) w_mem[cfg_addr] <= cfg_data;
    if (cfg_b_en) b_mem[cfg_addr[RW-1:0]] <= cfg_data;
    if (x_we) x_mem[x_idx] <= data_in;
    if (y_we) begin
      for (int p = 0; p < P; p++) y_mem[y_idx[p]] <= y_new[p];
    end
  end

endmodule

// File: tb/tb_fc_layer_engine.sv
// Bench for fc_layer_engine: a ReLU and a linear instance share all inputs; outputs are
// checked against directed constants and a plain-arithmetic reference model.
module tb_fc_layer_engine;
  localparam int TN  = 4;
  localparam int TM  = 4;
  localparam int TP  = 2;
  localparam int TT  = 16;
  localparam int LAT = (TM/TP)*(TN+2)+2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                 reset, s_valid, m_ready, cfg_we, cfg_sel;
  logic signed [TT-1:0] data_in, cfg_data;
  logic [3:0]           cfg_addr;
  logic                 s_ready_r, m_valid_r, busy_r, s_ready_l, m_valid_l, busy_l;
  logic signed [TT-1:0] data_out_r, data_out_l;

  fc_layer_engine #(.N(TN), .M(TM), .T(TT), .P(TP), .RELU(1), .SAT(1)) u_relu (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready_r), .data_in(data_in),
    .m_valid(m_valid_r), .m_ready(m_ready), .data_out(data_out_r), .cfg_we(cfg_we),
    .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .busy(busy_r));

  fc_layer_engine #(.N(TN), .M(TM), .T(TT), .P(TP), .RELU(0), .SAT(1)) u_lin (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready_l), .data_in(data_in),
    .m_valid(m_valid_l), .m_ready(m_ready), .data_out(data_out_l), .cfg_we(cfg_we),
    .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .busy(busy_l));

  int n_cmp = 0;
  int n_fail = 0;
  int W [TM*TN];
  int B [TM];
  int X [TN];
  int exp_r [TM];
  int exp_l [TM];
  int hs_cyc, first_mv;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int model(input int r, input bit relu);
    longint acc;
    acc = longint'(B[r]);
    for (int c = 0; c < TN; c++) acc += longint'(W[r*TN+c]) * longint'(X[c]);
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    if (relu && acc < 0) acc = 0;
    return int'(acc);
  endfunction

  task automatic set_exp_model();
    for (int r = 0; r < TM; r++) begin
      exp_r[r] = model(r, 1'b1);
      exp_l[r] = model(r, 1'b0);
    end
  endtask

  function automatic int rnd_full();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  function automatic int rnd_small();
    return int'($urandom_range(0, 200)) - 100;
  endfunction

  task automatic cfg_write(input bit sel, input int addr, input int val);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = 4'(addr); cfg_data = TT'(val);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic load_cfg();
    for (int i = 0; i < TM*TN; i++) cfg_write(1'b0, i, W[i]);
    for (int r = 0; r < TM; r++) cfg_write(1'b1, r, B[r]);
  endtask

  task automatic send_vec(input string tag, input bit gaps, input bit cfg_same, input int cval);
    int guard;
    for (int i = 0; i < TN; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          s_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      s_valid = 1'b1;
      data_in = TT'(X[i]);
      if (cfg_same && i == 0) begin
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 4'd0; cfg_data = TT'(cval);
      end
      guard = 0;
      while (!s_ready_r && guard < 200) begin
        @(posedge clk); #1;
        guard++;
      end
      hs_cyc = cyc;
      @(posedge clk); #1;
      cfg_we = 1'b0;
    end
    s_valid = 1'b0;
    chk({tag, "_sready_drop"}, s_ready_r, 0);
    chk({tag, "_busy_mac"}, busy_r, 1);
  endtask

  task automatic recv_vec(input string tag, input bit bp, input bit check_lat);
    int k, guard;
    bit hold_pend, got_first;
    logic signed [TT-1:0] hold_r, hold_l;
    k = 0; guard = 0; hold_pend = 0; got_first = 0; hold_r = '0; hold_l = '0;
    while (k < TM && guard < 500) begin
      if (m_valid_r && !got_first) begin
        got_first = 1'b1;
        first_mv  = cyc;
      end
      if (hold_pend) begin
        chk({tag, "_hold_valid"}, m_valid_r, 1);
        chk({tag, "_hold_data_r"}, data_out_r, hold_r);
        chk({tag, "_hold_data_l"}, data_out_l, hold_l);
      end
      m_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (m_valid_r && m_ready) begin
        chk($sformatf("%s_y%0d_relu", tag, k), data_out_r, exp_r[k]);
        chk($sformatf("%s_y%0d_lin", tag, k), data_out_l, exp_l[k]);
        chk($sformatf("%s_y%0d_lin_valid", tag, k), m_valid_l, 1);
        k++;
        hold_pend = 1'b0;
      end else if (m_valid_r) begin
        hold_pend = 1'b1;
        hold_r = data_out_r;
        hold_l = data_out_l;
      end
      @(posedge clk); #1;
      guard++;
    end
    chk({tag, "_word_count"}, k, TM);
    chk({tag, "_mvalid_after"}, m_valid_r, 0);
    chk({tag, "_mvalid_after_l"}, m_valid_l, 0);
    chk({tag, "_idle_after"}, busy_r, 0);
    if (check_lat) chk({tag, "_latency"}, first_mv - hs_cyc, LAT);
    m_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    int w0_old;
    reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0;
    cfg_addr = '0; cfg_data = '0; data_in = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_s_ready", s_ready_r, 0);
    chk("rst_m_valid", m_valid_r, 0);
    chk("rst_data_out", data_out_r, 0);
    chk("rst_busy", busy_r, 0);
    reset = 1'b0;
    #0;
    chk("idle_s_ready", s_ready_r, 1);

    // Identity weights, zero bias
    for (int r = 0; r < TM; r++) begin
      B[r] = 0;
      for (int c = 0; c < TN; c++) W[r*TN+c] = (r == c) ? 1 : 0;
    end
    load_cfg();
    X = '{3, -5, 7, 1};
    exp_r = '{3, 0, 7, 1};
    exp_l = '{3, -5, 7, 1};
    send_vec("t1", 1'b0, 1'b0, 0);
    recv_vec("t1", 1'b0, 1'b1);

    // Bias added after the product sum
    B = '{10, 10, -10, 0};
    load_cfg();
    exp_r = '{13, 5, 0, 1};
    exp_l = '{13, 5, -3, 1};
    send_vec("t2", 1'b1, 1'b0, 0);
    recv_vec("t2", 1'b0, 1'b1);

    // Saturation at both rails
    for (int i = 0; i < TM*TN; i++) W[i] = 32767;
    B = '{0, 0, 0, 0};
    load_cfg();
    X = '{32767, 32767, 32767, 32767};
    exp_r = '{32767, 32767, 32767, 32767};
    exp_l = '{32767, 32767, 32767, 32767};
    send_vec("t3p", 1'b0, 1'b0, 0);
    recv_vec("t3p", 1'b0, 1'b0);
    X = '{-32768, -32768, -32768, -32768};
    exp_r = '{0, 0, 0, 0};
    exp_l = '{-32768, -32768, -32768, -32768};
    send_vec("t3n", 1'b1, 1'b0, 0);
    recv_vec("t3n", 1'b1, 1'b0);

    // Random data with input gaps and output backpressure
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < TM*TN; i++) W[i] = (v % 2 == 0) ? rnd_full() : rnd_small();
      for (int r = 0; r < TM; r++) B[r] = rnd_full();
      for (int c = 0; c < TN; c++) X[c] = (v < 2) ? rnd_full() : rnd_small();
      load_cfg();
      set_exp_model();
      send_vec($sformatf("t4_%0d", v), 1'b1, 1'b0, 0);
      recv_vec($sformatf("t4_%0d", v), 1'b1, 1'b1);
    end

    // Reset in the middle of the MAC phase
    for (int c = 0; c < TN; c++) X[c] = rnd_small();
    send_vec("t5a", 1'b0, 1'b0, 0);
    m_ready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t5_busy_in_reset", busy_r, 0);
    chk("t5_mvalid_in_reset", m_valid_r, 0);
    reset = 1'b0;
    #0;
    chk("t5_sready_after", s_ready_r, 1);
    saw = 1'b0;
    for (int i = 0; i < 2*LAT; i++) begin
      if (m_valid_r || m_valid_l) saw = 1'b1;
      @(posedge clk); #1;
    end
    chk("t5_no_partial_out", saw, 0);
    chk("t5_idle", busy_r, 0);
    m_ready = 1'b0;
    for (int c = 0; c < TN; c++) X[c] = rnd_small();
    set_exp_model();
    send_vec("t5b", 1'b1, 1'b0, 0);
    recv_vec("t5b", 1'b0, 1'b1);

    // Configuration writes outside IDLE are dropped; in IDLE they apply at once
    for (int i = 0; i < TM*TN; i++) W[i] = rnd_small();
    for (int r = 0; r < TM; r++) B[r] = rnd_small();
    load_cfg();
    w0_old = W[0];
    for (int c = 0; c < TN; c++) X[c] = rnd_small();
    set_exp_model();
    send_vec("t6a", 1'b0, 1'b0, 0);
    cfg_write(1'b0, 0, 99);
    recv_vec("t6a", 1'b0, 1'b0);
    X = '{50, -20, 30, 40};
    set_exp_model();
    send_vec("t6b", 1'b0, 1'b0, 0);
    recv_vec("t6b", 1'b1, 1'b0);
    chk("t6_model_w0_kept", W[0], w0_old);
    W[0] = 99;
    set_exp_model();
    send_vec("t6c", 1'b0, 1'b1, 99);
    recv_vec("t6c", 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
